// File: rtl/serial_word_feeder.sv
// Serializes a handshaked word into an 8-bit clearable shift register.
// Optional even-parity bit after the data: define SERIALIZER_PARITY_EN.
module serial_word_feeder #(
  parameter int WIDTH        = 8,
  parameter int CLEAR_CYCLES = 1,
  parameter int LSB_FIRST    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       hold_i,
  output logic                       ser_o,
  output logic                       sr_clr_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(WIDTH+2)-1:0] bit_cnt_o
);

  localparam int CW  = $clog2(WIDTH+2);
  localparam int CCW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
`ifdef SERIALIZER_PARITY_EN
  localparam int TOT = WIDTH + 1;
`else
  localparam int TOT = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CCW-1:0]   clrc_q, clrc_d;
  logic             ser_q, ser_d;
  logic             srclr_q, srclr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      clrc_q  <= '0;
      ser_q   <= 1'b0;
      srclr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      clrc_q  <= clrc_d;
      ser_q   <= ser_d;
      srclr_q <= srclr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    clrc_d  = clrc_q;
    ser_d   = ser_q;
    srclr_d = srclr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sreg_d = data_i;
          cnt_d  = '0;
          clrc_d = '0;
          busy_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          par_d  = ^data_i;
`endif
          if (CLEAR_CYCLES == 0) begin
            state_d = SHIFT;
            srclr_d = 1'b0;
            ser_d   = first_bit(data_i);
          end else begin
            state_d = CLEAR;
            srclr_d = 1'b1;
            ser_d   = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (!hold_i) begin
          if (clrc_q == CCW'(CLEAR_CYCLES-1)) begin
            state_d = SHIFT;
            srclr_d = 1'b0;
            ser_d   = first_bit(sreg_q);
          end else begin
            clrc_d = clrc_q + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!hold_i) begin
          cnt_d  = cnt_q + 1'b1;
          sreg_d = shift_word(sreg_q);
          if (cnt_q == CW'(TOT-1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            ser_d   = 1'b0;
          end
`ifdef SERIALIZER_PARITY_EN
          else if (cnt_q == CW'(WIDTH-1)) begin
            ser_d = par_q;
          end
`endif
          else begin
            ser_d = first_bit(shift_word(sreg_q));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is a pure state decode so no input reaches an output
  assign in_ready_o = (state_q == IDLE);
  assign ser_o      = ser_q;
  assign sr_clr_o   = srclr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign bit_cnt_o  = cnt_q;

endmodule
